ifu_ifid_queue: RTL and testbench
=================================

Name: ifu_ifid_queue

Overview:
- Fetch-side producer for the decode stage: buffers fetched instructions and drives the IF/ID outputs (instruction, PC, old PC, branch-prediction bit) that the decoder consumes.
- Absorbs decoder stalls so that fetch responses are never lost.
- Injects NOPs when empty and discards all contents on a pipeline flush.
- Sits between the instruction-memory response path and the decoder.

Parameters:
- DEPTH, 4, FIFO entries behind the output register (power of two, ≥2)
- INST_W, 32, instruction width
- ADDR_W, 32, instruction address width
- NOP_INST, 32'h00000013, instruction driven when the output is invalid (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_valid_i  in  1  fetch response valid
- fetch_ready_o  out  1  queue can accept this cycle
- fetch_inst_i  in  INST_W  fetched instruction
- fetch_addr_i  in  ADDR_W  PC of the fetched instruction
- fetch_old_pc_i  in  ADDR_W  fall-through PC recorded for misprediction recovery
- fetch_taken_i  in  1  branch predicted taken
- stall_i  in  1  decoder holding; the IF/ID output must not advance
- flush_i  in  1  redirect; discard everything
- inst_valid_o  out  1  output instruction is real
- inst_o  out  INST_W  to decoder
- inst_addr_o  out  ADDR_W  to decoder
- old_pc_o  out  ADDR_W  to decoder
- branch_taken_o  out  1  to decoder
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; pointers and count_o = 0.
  - inst_valid_o = 0, inst_o = NOP_INST, inst_addr_o = 0, old_pc_o = 0, branch_taken_o = 0.
  - Reset mid-operation drops all entries; no partial state survives.
- Handshake:
  - Push occurs when fetch_valid_i && fetch_ready_o.
  - fetch_ready_o = (count_o < DEPTH) && !flush_i, combinational.
  - No push when the FIFO is full, even if a pop happens in the same cycle.
- Flush has the highest priority after rst:
  - The FIFO is cleared and the output register is loaded with NOP (valid = 0, addr/old_pc = 0, taken = 0).
  - Any same-cycle push is dropped.
  - stall_i is ignored on a flush cycle.
- Advance (!stall_i, no flush), output register loaded from the first available source:
  1. FIFO head, which is popped; a same-cycle push goes to the tail.
  2. Otherwise, when the FIFO is empty and a push is occurring: bypass directly from the fetch_* inputs. Nothing is written into the FIFO.
  3. Otherwise: NOP with valid = 0.
- Hold (stall_i=1):
  - Output register unchanged.
  - A push is written into the FIFO tail.
- Latency:
  - With an empty FIFO and no stall, an instruction accepted at edge N is on the outputs after edge N (1 cycle).
  - Order is strictly FIFO; there is no reordering.
- Pointers:
  - Read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = MSBs differ and the low bits are equal.
  - empty = the pointers are equal.
- Count update per cycle: count_o += push_to_fifo − pop. Simultaneous push and pop leaves the count unchanged.
- Empty entries are never presented as valid. The decoder sees NOP_INST whenever inst_valid_o = 0.

Decomposition:
- Package ifu_pkg:
  - typedef struct ifid_entry_t {inst, addr, old_pc, taken}.
  - localparam NOP_INST.
  - Width constants reused from the global defines.
- Sub-module ifu_sync_fifo (generic ifid_entry_t ring buffer):
  - Signals: push/pop/clear, full/empty/count.
- ifu_ifid_queue contains the bypass/NOP mux and the output register.

Test Plan:
- Reset: assert rst for 2 cycles after traffic → inst_valid_o = 0, inst_o = 32'h00000013, count_o = 0, fetch_ready_o = 1.
- Bypass: empty queue, no stall, push inst 32'h00500093 @ 0x80000000 at edge N → after edge N inst_o = 32'h00500093, inst_addr_o = 0x80000000, inst_valid_o = 1, count_o = 0.
- Stall fill:
  - With stall_i = 1, push 4 instructions at 0x100, 0x104, 0x108, 0x10C → count_o = 4, fetch_ready_o = 0.
  - A 5th fetch_valid_i is not accepted.
  - Release stall → outputs present 0x100…0x10C in order, one per cycle, then NOP with valid = 0.
- Push and pop while non-empty: count_o = 2, no stall, push each cycle → count_o stays 2 and order is preserved.
- Flush collision: count_o = 3, flush_i = 1 with fetch_valid_i = 1 and stall_i = 1 in the same cycle → next cycle count_o = 0, inst_valid_o = 0, inst_o = NOP, and the pushed instruction never appears.
- Wrap-around: 3·DEPTH pushes and pops with a random stall pattern (addresses 0x0…0x2C) → every address emerges once, in order, with branch_taken_o and old_pc_o matching their pushed values.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the IF/ID queue: the buffered fetch entry and the NOP encoding.
package ifu_pkg;

    localparam int IFU_INST_W = 32;
    localparam int IFU_ADDR_W = 32;
    localparam logic [IFU_INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [IFU_INST_W-1:0] inst;
        logic [IFU_ADDR_W-1:0] addr;
        logic [IFU_ADDR_W-1:0] old_pc;
        logic                  taken;
    } ifid_entry_t;

    function automatic ifid_entry_t nop_entry();
        ifid_entry_t e;
        e.inst   = NOP_INST;
        e.addr   = '0;
        e.old_pc = '0;
        e.taken  = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Ring buffer of ifid_entry_t with extra-MSB pointers (full/empty from pointer compare).
module ifu_sync_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  ifid_entry_t wdata_i,
    output ifid_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [PW-1:0] count_o
);

    localparam int AW = PW - 1;

    ifid_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i && !full_o) wptr_d = wptr_q + PW'(1);
            if (pop_i && !empty_o) rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset: stale slots are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && !clear_i && push_i && !full_o)
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ifu_ifid_queue.sv
// IF/ID producer: FIFO plus output register with bypass, NOP injection and flush.
module ifu_ifid_queue
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          INST_W   = IFU_INST_W,
    parameter int          ADDR_W   = IFU_ADDR_W,
    parameter logic [31:0] NOP_CODE = NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [INST_W-1:0]        fetch_inst_i,
    input  logic [ADDR_W-1:0]        fetch_addr_i,
    input  logic [ADDR_W-1:0]        fetch_old_pc_i,
    input  logic                     fetch_taken_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic                     inst_valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic [ADDR_W-1:0]        old_pc_o,
    output logic                     branch_taken_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH) + 1;

    ifid_entry_t fetch_e, head_e, out_q, out_d, nop_e;
    logic        valid_q, valid_d;
    logic        full, empty, push, pop, bypass, push_fifo;

    always_comb begin
        fetch_e        = nop_entry();
        fetch_e.inst   = fetch_inst_i;
        fetch_e.addr   = fetch_addr_i;
        fetch_e.old_pc = fetch_old_pc_i;
        fetch_e.taken  = fetch_taken_i;
        nop_e          = nop_entry();
        nop_e.inst     = NOP_CODE;
    end

    assign fetch_ready_o = !full && !flush_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign pop           = !flush_i && !stall_i && !empty;
    // An empty FIFO with an advancing output hands the fetch straight to the register.
    assign bypass        = !flush_i && !stall_i && empty && push;
    assign push_fifo     = push && !bypass;

    ifu_sync_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_fifo),
        .pop_i   (pop),
        .clear_i (flush_i),
        .wdata_i (fetch_e),
        .rdata_o (head_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (flush_i) begin
            out_d   = nop_e;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (!empty) begin
                out_d   = head_e;
                valid_d = 1'b1;
            end else if (push) begin
                out_d   = fetch_e;
                valid_d = 1'b1;
            end else begin
                out_d   = nop_e;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= nop_e;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign inst_valid_o   = valid_q;
    assign inst_o         = out_q.inst;
    assign inst_addr_o    = out_q.addr;
    assign old_pc_o       = out_q.old_pc;
    assign branch_taken_o = out_q.taken;

endmodule

// File: tb/tb_ifu_ifid_queue.sv
// Directed bench for ifu_ifid_queue: reset, bypass, stall fill/drain, flush, wrap-around.
module tb_ifu_ifid_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i, fetch_ready_o, fetch_taken_i;
    logic [31:0] fetch_inst_i, fetch_addr_i, fetch_old_pc_i;
    logic        stall_i, flush_i;
    logic        inst_valid_o, branch_taken_o;
    logic [31:0] inst_o, inst_addr_o, old_pc_o;
    logic [2:0]  count_o;

    int n_cmp = 0;
    int n_err = 0;

    ifu_ifid_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_ready_o  (fetch_ready_o),
        .fetch_inst_i   (fetch_inst_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_old_pc_i (fetch_old_pc_i),
        .fetch_taken_i  (fetch_taken_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .old_pc_o       (old_pc_o),
        .branch_taken_o (branch_taken_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] addr);
        fetch_valid_i  = v;
        fetch_addr_i   = addr;
        fetch_inst_i   = 32'hC000_0000 | addr;
        fetch_old_pc_i = addr + 32'h1000;
        fetch_taken_i  = addr[2];
    endtask

    task automatic chk_out(input string tag, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd1);
        chk({tag, ".inst"},  inst_o, 32'hC000_0000 | addr);
        chk({tag, ".addr"},  inst_addr_o, addr);
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({tag, ".inst"},  inst_o, NOP);
    endtask

    int pushed, popped, cyc;
    logic stall_at_edge;
    logic [31:0] exp_addr;

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        tick(); tick();
        rst = 1'b0;
        chk_nop("reset0");
        chk("reset0.count", {29'd0, count_o}, 32'd0);
        chk("reset0.ready", {31'd0, fetch_ready_o}, 32'd1);

        // Bypass through an empty queue
        fetch_valid_i = 1'b1; fetch_addr_i = 32'h8000_0000; fetch_inst_i = 32'h0050_0093;
        fetch_old_pc_i = 32'h8000_0004; fetch_taken_i = 1'b0;
        tick();
        chk("byp.inst",  inst_o, 32'h0050_0093);
        chk("byp.addr",  inst_addr_o, 32'h8000_0000);
        chk("byp.valid", {31'd0, inst_valid_o}, 32'd1);
        chk("byp.count", {29'd0, count_o}, 32'd0);
        drive(1'b0, 32'h0);
        tick();
        chk_nop("byp.idle");

        // Fill under stall, 5th fetch refused
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i));
            tick();
        end
        chk("fill.count", {29'd0, count_o}, 32'd4);
        chk("fill.ready", {31'd0, fetch_ready_o}, 32'd0);
        drive(1'b1, 32'h110);
        tick();
        chk("fill5.count", {29'd0, count_o}, 32'd4);
        chk_nop("fill.hold");
        drive(1'b0, 32'h0);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("drain", 32'h100 + 32'(4 * i));
            chk("drain.count", {29'd0, count_o}, 32'(3 - i));
        end
        tick();
        chk_nop("drain.end");

        // Steady push and pop with two entries buffered
        stall_i = 1'b1;
        drive(1'b1, 32'h200); tick();
        drive(1'b1, 32'h204); tick();
        chk("pp.count0", {29'd0, count_o}, 32'd2);
        stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i));
            tick();
            chk_out("pp", 32'h200 + 32'(4 * i));
            chk("pp.count", {29'd0, count_o}, 32'd2);
        end
        drive(1'b0, 32'h0);
        tick(); chk_out("pp.tail0", 32'h20C);
        tick(); chk_out("pp.tail1", 32'h210);
        tick(); chk_nop("pp.end");

        // Flush with a colliding push and stall
        drive(1'b1, 32'h2F0); tick();
        chk_out("fl.pre", 32'h2F0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i));
            tick();
        end
        chk("fl.count3", {29'd0, count_o}, 32'd3);
        drive(1'b1, 32'h30C);
        flush_i = 1'b1;
        #1;
        chk("fl.ready", {31'd0, fetch_ready_o}, 32'd0);
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl.count", {29'd0, count_o}, 32'd0);
        chk_nop("fl.out");
        chk("fl.addr", inst_addr_o, 32'd0);
        tick();
        chk_nop("fl.after");
        chk("fl.count2", {29'd0, count_o}, 32'd0);

        // Wrap-around with random stalls
        pushed = 0; popped = 0; cyc = 0;
        while (popped < 12 && cyc < 300) begin
            stall_i = (pushed < 12 || cyc[0]) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(pushed < 12, 32'(4 * pushed));
            #1;
            if (fetch_valid_i && fetch_ready_o) pushed++;
            stall_at_edge = stall_i;
            tick();
            cyc++;
            if (!stall_at_edge && inst_valid_o) begin
                exp_addr = 32'(4 * popped);
                chk("wrap.addr",  inst_addr_o, exp_addr);
                chk("wrap.inst",  inst_o, 32'hC000_0000 | exp_addr);
                chk("wrap.oldpc", old_pc_o, exp_addr + 32'h1000);
                chk("wrap.taken", {31'd0, branch_taken_o}, {31'd0, exp_addr[2]});
                popped++;
            end
        end
        chk("wrap.popped", 32'(popped), 32'd12);
        stall_i = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        chk_nop("wrap.end");

        // Reset mid-operation
        drive(1'b1, 32'h400); tick();
        stall_i = 1'b1;
        drive(1'b1, 32'h404); tick();
        drive(1'b1, 32'h408); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; stall_i = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        chk_nop("reset1");
        chk("reset1.count", {29'd0, count_o}, 32'd0);
        chk("reset1.ready", {31'd0, fetch_ready_o}, 32'd1);
        chk("reset1.addr",  inst_addr_o, 32'd0);
        tick();
        chk_nop("reset1.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
